// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the brick-game flow controller.
//   state_e       : FSM state encodings (also the value driven on the state port)
//   *_DEF         : default parameter values for game_flow_ctrl
//   CNT_W         : width of the frame counter
//   LEVEL_MAX     : highest difficulty level
//   popcount3     : number of set bits in a 3-bit vector
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_MISS  = 3'd4,
    ST_WIN   = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int END_FRAMES_DEF   = 120;
  localparam int BRICK_PTS_DEF    = 10;

  localparam int         CNT_W     = 8;
  localparam logic [1:0] LEVEL_MAX = 2'd2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge -- registers an already-synchronised button level and produces
// a one-cycle press pulse on its rising edge (a held button gives one pulse).
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset (clears the history register)
//   btn_i   : button level
//   press_o : high while btn_i is high and its registered copy is low
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl -- game-level sequencer for a three-brick ball game.
// Tracks lives, score, level and surviving bricks, and gates the game core.
//   clk         : system clock, all logic on posedge
//   reset       : synchronous active-low reset
//   frame_tick  : one-cycle pulse per video frame (counts SERVE / WIN delays)
//   start_btn   : start/pause button level, synchronised to clk
//   brick_hit   : per-brick one-cycle hit pulses
//   ball_lost   : one-cycle pulse when the ball passes the bar
//   run         : core motion enable, high exactly while in PLAY
//   core_rst_n  : active-low core restart, low in reset and first SERVE cycle
//   level       : difficulty select 0..2
//   brick_alive : per-brick display enable
//   lives       : remaining lives
//   score       : saturating score
//   state       : current FSM state code (game_pkg::state_e)
// Handshake: none; all inputs are single-cycle pulses or levels sampled on
// every posedge, and every output is a register updated on that same edge.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int END_FRAMES   = END_FRAMES_DEF,
  parameter int BRICK_PTS    = BRICK_PTS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [2:0] brick_hit,
  input  logic       ball_lost,
  output logic       run,
  output logic       core_rst_n,
  output logic [1:0] level,
  output logic [2:0] brick_alive,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] END_LOAD   = CNT_W'(END_FRAMES);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       level_q, level_d;
  logic [2:0]       alive_q, alive_d;
  logic             run_q;
  logic             core_rst_n_q;

  logic       press;
  logic [2:0] newly;
  logic [31:0] sum;

  btn_edge u_btn_edge (
    .clk_i   (clk),
    .rst_ni  (reset),
    .btn_i   (start_btn),
    .press_o (press)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lives_q      <= LIVES_LOAD;
      score_q      <= '0;
      level_q      <= '0;
      alive_q      <= 3'b111;
      run_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      level_q      <= level_d;
      alive_q      <= alive_d;
      // Registered from the next state so run and core_rst_n line up with state.
      run_q        <= (state_d == ST_PLAY);
      core_rst_n_q <= !((state_d == ST_SERVE) && (state_q != ST_SERVE));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    alive_d = alive_q;
    // Only bricks still standing score; repeat hits on a cleared brick vanish here.
    newly   = brick_hit & alive_q;
    sum     = 32'(score_q) + 32'(popcount3(newly)) * 32'(BRICK_PTS);

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
          lives_d = LIVES_LOAD;
          score_d = '0;
          level_d = '0;
          alive_d = 3'b111;
        end
      end

      ST_SERVE: begin
        // Leave one cycle after the tick that reaches zero.
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_PLAY: begin
        alive_d = alive_q & ~brick_hit;
        score_d = (sum > 32'd255) ? 8'hFF : sum[7:0];
        // Clearing the last brick outranks a simultaneous miss or press.
        if ((newly != 3'b000) && (alive_d == 3'b000)) begin
          state_d = ST_WIN;
          cnt_d   = END_LOAD;
        end else if (press) begin
          state_d = ST_PAUSE;
        end else if (ball_lost) begin
          state_d = ST_MISS;
        end
      end

      ST_PAUSE: begin
        if (press) begin
          state_d = ST_PLAY;
        end
      end

      ST_MISS: begin
        if (lives_q <= 2'd1) begin
          lives_d = '0;
          state_d = ST_OVER;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      ST_WIN: begin
        if (cnt_q == '0) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
          alive_d = 3'b111;
          level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 2'd1;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_OVER: begin
        if (press) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run         = run_q;
  assign core_rst_n  = core_rst_n_q;
  assign level       = level_q;
  assign brick_alive = alive_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl -- directed bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic [2:0] brick_hit;
  logic       ball_lost;
  logic       run;
  logic       core_rst_n;
  logic [1:0] level;
  logic [2:0] brick_alive;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;

  int n_checks;
  int n_errors;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_MISS  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  game_flow_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .brick_hit   (brick_hit),
    .ball_lost   (ball_lost),
    .run         (run),
    .core_rst_n  (core_rst_n),
    .level       (level),
    .brick_alive (brick_alive),
    .lives       (lives),
    .score       (score),
    .state       (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  // Full press: one cycle high, one cycle low so the next press is a new edge.
  task automatic press_btn();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic hit(input logic [2:0] v);
    brick_hit = v;
    step();
    brick_hit = 3'b000;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_run"}, 32'(run), 0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_alive"}, 32'(brick_alive), 7);
    chk({tag, "_lives"}, 32'(lives), 3);
    chk({tag, "_score"}, 32'(score), 0);
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    int exp_score;
    int exp_level;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    brick_hit  = 3'b000;
    ball_lost  = 1'b0;

    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b1;
    step();
    chk("rst_release_core", 32'(core_rst_n), 1);
    chk("rst_release_state", 32'(state), 32'(S_IDLE));

    // Start: SERVE next cycle with a one-cycle core restart; held button is one press.
    start_btn = 1'b1;
    step();
    chk("serve_entry_state", 32'(state), 32'(S_SERVE));
    chk("serve_entry_core", 32'(core_rst_n), 0);
    step();
    chk("serve_core_back", 32'(core_rst_n), 1);
    chk("serve_held_state", 32'(state), 32'(S_SERVE));
    start_btn = 1'b0;
    ticks(59);
    chk("serve_59_ticks", 32'(state), 32'(S_SERVE));
    ticks(1);
    chk("serve_cnt_zero", 32'(state), 32'(S_SERVE));
    step();
    chk("play_state", 32'(state), 32'(S_PLAY));
    chk("play_run", 32'(run), 1);
    ticks(5);
    chk("play_ignores_tick", 32'(state), 32'(S_PLAY));

    // Two simultaneous hits, then a repeat hit on a cleared brick.
    hit(3'b011);
    chk("hit011_alive", 32'(brick_alive), 4);
    chk("hit011_score", 32'(score), 20);
    hit(3'b001);
    chk("rehit_alive", 32'(brick_alive), 4);
    chk("rehit_score", 32'(score), 20);

    // Pause: events ignored, held button does not toggle back.
    start_btn = 1'b1;
    step();
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    chk("pause_run", 32'(run), 0);
    brick_hit = 3'b100;
    ball_lost = 1'b1;
    step();
    brick_hit = 3'b000;
    ball_lost = 1'b0;
    step();
    chk("pause_held_state", 32'(state), 32'(S_PAUSE));
    chk("pause_alive", 32'(brick_alive), 4);
    chk("pause_lives", 32'(lives), 3);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    chk("unpause_state", 32'(state), 32'(S_PLAY));
    start_btn = 1'b0;
    step();
    chk("unpause_run", 32'(run), 1);

    // Three misses, each from a fresh PLAY.
    for (int m = 0; m < 3; m++) begin
      ball_lost = 1'b1;
      step();
      ball_lost = 1'b0;
      chk("miss_state", 32'(state), 32'(S_MISS));
      step();
      chk("miss_lives", 32'(lives), 32'(2 - m));
      if (m < 2) begin
        chk("miss_reserve", 32'(state), 32'(S_SERVE));
        chk("miss_core_pulse", 32'(core_rst_n), 0);
        ticks(60);
        step();
        chk("miss_replay", 32'(state), 32'(S_PLAY));
      end else begin
        chk("over_state", 32'(state), 32'(S_OVER));
        step();
        chk("over_run", 32'(run), 0);
        chk("over_score", 32'(score), 20);
      end
    end
    press_btn();
    chk("over_to_idle", 32'(state), 32'(S_IDLE));

    // New game; last brick and ball_lost together -> WIN, lives kept.
    press_btn();
    chk("new_lives", 32'(lives), 3);
    chk("new_score", 32'(score), 0);
    chk("new_alive", 32'(brick_alive), 7);
    ticks(60);
    step();
    chk("new_play", 32'(state), 32'(S_PLAY));
    hit(3'b011);
    brick_hit = 3'b100;
    ball_lost = 1'b1;
    step();
    brick_hit = 3'b000;
    ball_lost = 1'b0;
    chk("win_state", 32'(state), 32'(S_WIN));
    chk("win_lives", 32'(lives), 3);
    chk("win_score", 32'(score), 30);
    chk("win_alive", 32'(brick_alive), 0);
    ticks(119);
    chk("win_119", 32'(state), 32'(S_WIN));
    ticks(1);
    step();
    chk("win_to_serve", 32'(state), 32'(S_SERVE));
    chk("win_level", 32'(level), 1);
    chk("win_alive_refill", 32'(brick_alive), 7);
    chk("win_core_pulse", 32'(core_rst_n), 0);

    // Reset in the middle of WIN with 50 frames left.
    ticks(60);
    step();
    hit(3'b111);
    chk("win2_state", 32'(state), 32'(S_WIN));
    ticks(70);
    reset = 1'b0;
    step();
    chk_reset_vals("midwin_rst");
    reset = 1'b1;
    step();

    // Score and level saturation over nine cleared rounds.
    press_btn();
    exp_score = 0;
    exp_level = 0;
    for (int r = 0; r < 9; r++) begin
      ticks(60);
      step();
      hit(3'b111);
      exp_score = (exp_score + 30 > 255) ? 255 : exp_score + 30;
      chk("sat_round_score", 32'(score), 32'(exp_score));
      ticks(120);
      step();
      exp_level = (exp_level < 2) ? exp_level + 1 : 2;
      chk("sat_round_level", 32'(level), 32'(exp_level));
    end
    chk("sat_score", 32'(score), 255);
    chk("sat_level", 32'(level), 2);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at new game (1..3).
REQ-002 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before play starts (1..255).
REQ-003 Parameter END_FRAMES, default 120: frame ticks spent in WIN before the next level (1..255).
REQ-004 Parameter BRICK_PTS, default 10: score added per newly cleared brick.
REQ-005 clk  in  1  single system clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-008 start_btn  in  1  start/pause button level, already synchronised to clk.
REQ-009 brick_hit  in  3  one-cycle pulse per brick when the ball strikes it.
REQ-010 ball_lost  in  1  one-cycle pulse when the ball passes the bar.
REQ-011 run  out  1  game core motion enable (drives core str); high only in PLAY.
REQ-012 core_rst_n  out  1  active-low restart pulse to the game core.
REQ-013 level  out  2  difficulty select (drives core sw).
REQ-014 brick_alive  out  3  per-brick display enable.
REQ-015 lives  out  2  remaining lives.
REQ-016 score  out  8  score, saturating.
REQ-017 state  out  3  current FSM state code.

Function
REQ-018 Start press SHALL be start_btn high with its one-cycle-delayed register low; a held button SHALL produce exactly one press.
REQ-019 FSM states SHALL be: IDLE, SERVE, PLAY, PAUSE, MISS, WIN, OVER.
REQ-020 IDLE: on press -> SERVE; lives=LIVES_INIT, score=0, level=0, brick_alive=3'b111.
REQ-021 SERVE: core_rst_n SHALL be low for exactly the first cycle in SERVE. The frame counter loads SERVE_FRAMES on entry and decrements per frame_tick. The transition to PLAY SHALL occur the cycle after the tick that brings it to 0.
REQ-022 PLAY: press -> PAUSE. Any newly cleared brick that leaves brick_alive==0 -> WIN. Otherwise ball_lost -> MISS.
REQ-023 PAUSE: run low, all events ignored; press -> PLAY.
REQ-024 MISS: single-cycle state; lives decrements by 1; next state is OVER if lives was 1, else SERVE.
REQ-025 WIN: the counter loads END_FRAMES; at 0 -> SERVE with brick_alive=3'b111 and level incremented, saturating at 2.
REQ-026 OVER: outputs hold (score frozen); press -> IDLE.
REQ-027 brick_hit[i] SHALL clear brick_alive[i] only in PLAY. A hit on an already cleared brick SHALL be ignored.
REQ-028 Score SHALL add BRICK_PTS per newly cleared brick, counting simultaneous hits individually. The sum saturates at 255.
REQ-029 When the last brick is cleared and ball_lost occur in the same cycle, WIN SHALL take priority and lives stay unchanged.
REQ-030 brick_hit and ball_lost SHALL be ignored outside PLAY; frame_tick SHALL be ignored outside SERVE/WIN.
REQ-031 All outputs SHALL be registered; changes appear one clk after the causing input.
REQ-032 run SHALL equal (state==PLAY) registered.

Reset
REQ-033 reset low at a clock edge SHALL force IDLE, run=0, core_rst_n=0, level=0, brick_alive=3'b111, lives=LIVES_INIT, score=0, counter=0, press register=0, regardless of the current state.
REQ-034 core_rst_n SHALL remain low while reset is low and return high the cycle after reset releases, unless entering SERVE.

Structure
REQ-035 State encodings (IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, WIN=5, OVER=6) and default constants SHALL live in shared package game_pkg.
REQ-036 Press detection SHALL be one sub-module, btn_edge (register plus rising-edge pulse). Everything else stays in game_flow_ctrl.

Verification
REQ-037 Reset, then one press -> SERVE next cycle with core_rst_n low for 1 cycle; PLAY after 60 frame_ticks; run=1.
REQ-038 In PLAY, brick_hit=3'b011 in one cycle -> brick_alive=3'b100, score=20. Repeat brick_hit[0] -> no change.
REQ-039 Three ball_lost pulses, each from a fresh PLAY -> lives 2,1,0. After the third, state=OVER and run=0; a press -> IDLE.
REQ-040 brick_hit[2] (last brick) and ball_lost in the same cycle -> WIN, lives unchanged. After 120 ticks -> SERVE, level=1, brick_alive=3'b111.
REQ-041 Press in PLAY -> PAUSE; brick_hit/ball_lost ignored; a held button gives no second toggle; a second press -> PLAY.
REQ-042 Reset asserted mid-WIN with counter=50 -> IDLE next cycle, all outputs at reset values.
